// File: rtl/cii_char_grid_mapper.sv
// Character-grid mapper: turns the VGA scan position into character column/row,
// glyph pixel offsets and a linear character-RAM address. Each axis runs a small
// lock FSM that tracks the scan by +1 steps only. Any discontinuity drops lock
// until the next grid origin, so counters never drift out of step with the beam.
module cii_char_grid_mapper #(
  parameter int CHARW = 70,
  parameter int CHARH = 30,
  parameter int PIXW  = 9,
  parameter int PIXH  = 16,
  parameter int X_OFF = 5,
  parameter int Y_OFF = 0,
  parameter int AW    = 10,
  parameter int CXW   = 7,
  parameter int CYW   = 5,
  parameter int PW    = 4,
  parameter int CAW   = 12
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           pix_en,
  input  logic [AW-1:0]  h_addr,
  input  logic [AW-1:0]  v_addr,
  input  logic [CYW-1:0] scroll_row,
  output logic [CXW-1:0] char_x,
  output logic [CYW-1:0] char_y,
  output logic [PW-1:0]  pixel_x,
  output logic [PW-1:0]  pixel_y,
  output logic [CAW-1:0] char_addr,
  output logic           in_grid,
  output logic           out_valid
);

  typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_e;

  // Offsets are subtracted in AW+1 bits. An address below the origin then wraps
  // to a value >= 2^AW, so a single unsigned "< span" test covers both edges.
  localparam logic [AW:0]  X_OFF_W  = (AW+1)'(X_OFF);
  localparam logic [AW:0]  Y_OFF_W  = (AW+1)'(Y_OFF);
  localparam logic [AW:0]  H_SPAN   = (AW+1)'(CHARW*PIXW);
  localparam logic [AW:0]  V_SPAN   = (AW+1)'(CHARH*PIXH);
  localparam logic [AW:0]  ONE_W    = (AW+1)'(1);
  localparam logic [PW-1:0] PX_LAST = PW'(PIXW-1);
  localparam logic [PW-1:0] PY_LAST = PW'(PIXH-1);
  localparam logic [CYW:0] CHARH_W  = (CYW+1)'(CHARH);

  lock_e          h_st, h_st_n, v_st, v_st_n;
  logic [AW-1:0]  last_h, last_v;
  logic [PW-1:0]  px, px_n, py, py_n;
  logic [CXW-1:0] cx, cx_n;
  logic [CYW-1:0] row, row_n, scr, scr_n;

  logic [AW:0]    h_rel, v_rel;
  logic           h_in, v_in, h_step, h_rep, v_step, v_new, scr_ok;
  logic [CYW:0]   ysum;
  logic [CYW-1:0] cy_n;
  logic [CAW-1:0] addr_n;
  logic           grid_n;

  assign h_rel  = {1'b0, h_addr} - X_OFF_W;
  assign v_rel  = {1'b0, v_addr} - Y_OFF_W;
  assign h_in   = h_rel < H_SPAN;
  assign v_in   = v_rel < V_SPAN;
  assign h_step = {1'b0, h_addr} == ({1'b0, last_h} + ONE_W);
  assign h_rep  = h_addr == last_h;
  assign v_step = {1'b0, v_addr} == ({1'b0, last_v} + ONE_W);
  assign v_new  = v_addr != last_v;
  assign scr_ok = {1'b0, scroll_row} < CHARH_W;

  // Horizontal lock: origin relocks, +1 advances, a repeat holds, anything else drops
  always_comb begin
    h_st_n = h_st;
    px_n   = px;
    cx_n   = cx;
    if (h_rel == '0) begin
      h_st_n = LOCKED;
      px_n   = '0;
      cx_n   = '0;
    end else if (!h_in) begin
      h_st_n = UNLOCKED;
      px_n   = '0;
      cx_n   = '0;
    end else if (h_st == LOCKED && h_step) begin
      if (px == PX_LAST) begin
        px_n = '0;
        cx_n = cx + 1'b1;
      end else begin
        px_n = px + 1'b1;
      end
    end else if (h_st == LOCKED && h_rep) begin
      px_n = px;
    end else begin
      h_st_n = UNLOCKED;
      px_n   = '0;
      cx_n   = '0;
    end
  end

  // Vertical lock: only moves when the line number changes; scroll is captured at frame top
  always_comb begin
    v_st_n = v_st;
    py_n   = py;
    row_n  = row;
    scr_n  = scr;
    if (v_new) begin
      if (v_rel == '0) begin
        v_st_n = LOCKED;
        py_n   = '0;
        row_n  = '0;
        scr_n  = scr_ok ? scroll_row : '0;
      end else if (v_in && v_st == LOCKED && v_step) begin
        if (py == PY_LAST) begin
          py_n  = '0;
          row_n = row + 1'b1;
        end else begin
          py_n = py + 1'b1;
        end
      end else begin
        v_st_n = UNLOCKED;
        py_n   = '0;
        row_n  = '0;
      end
    end
  end

  // Scrolled row wraps with a single conditional subtract; address is a constant multiply
  always_comb begin
    ysum   = {1'b0, row_n} + {1'b0, scr_n};
    cy_n   = (ysum >= CHARH_W) ? CYW'(ysum - CHARH_W) : CYW'(ysum);
    addr_n = CAW'(cy_n) * CAW'(CHARW) + CAW'(cx_n);
    grid_n = (h_st_n == LOCKED) && (v_st_n == LOCKED);
  end

  // State and registered outputs; everything holds on cycles without pix_en
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_st      <= UNLOCKED;
      v_st      <= UNLOCKED;
      last_h    <= '1;
      last_v    <= '1;
      px        <= '0;
      cx        <= '0;
      py        <= '0;
      row       <= '0;
      scr       <= '0;
      char_x    <= '0;
      char_y    <= '0;
      pixel_x   <= '0;
      pixel_y   <= '0;
      char_addr <= '0;
      in_grid   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= pix_en;
      if (pix_en) begin
        h_st      <= h_st_n;
        v_st      <= v_st_n;
        last_h    <= h_addr;
        last_v    <= v_addr;
        px        <= px_n;
        cx        <= cx_n;
        py        <= py_n;
        row       <= row_n;
        scr       <= scr_n;
        in_grid   <= grid_n;
        char_x    <= grid_n ? cx_n   : '0;
        char_y    <= grid_n ? cy_n   : '0;
        pixel_x   <= grid_n ? px_n   : '0;
        pixel_y   <= grid_n ? py_n   : '0;
        char_addr <= grid_n ? addr_n : '0;
      end
    end
  end

endmodule

// File: tb/tb_cii_char_grid_mapper.sv
// Bench for cii_char_grid_mapper: a position-based reference model (lock flags
// plus divide/modulo on the scan address) checked every cycle, directed scenarios
// with hand-computed literal pins, then a randomized scan with jumps and stalls.
module tb_cii_char_grid_mapper;
  localparam int CHARW = 70, CHARH = 30, PIXW = 9, PIXH = 16;
  localparam int X_OFF = 5, Y_OFF = 0;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pix_en = 1'b0;
  logic [9:0]  h_addr = '0;
  logic [9:0]  v_addr = '0;
  logic [4:0]  scroll_row = '0;
  logic [6:0]  char_x;
  logic [4:0]  char_y;
  logic [3:0]  pixel_x, pixel_y;
  logic [11:0] char_addr;
  logic        in_grid, out_valid;

  int n_vec = 0;
  int n_err = 0;

  cii_char_grid_mapper dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .h_addr(h_addr), .v_addr(v_addr),
    .scroll_row(scroll_row), .char_x(char_x), .char_y(char_y), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .char_addr(char_addr), .in_grid(in_grid), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, got, exp);
    end
  endtask

  // Reference model: lock is a flag, position is derived from the address itself
  bit m_hl, m_vl;
  int m_lh, m_lv, m_scr;
  int e_cx, e_cy, e_px, e_py, e_ad;
  bit e_ig, e_ov;

  task automatic model_reset();
    m_hl = 0; m_vl = 0; m_lh = 1023; m_lv = 1023; m_scr = 0;
    e_cx = 0; e_cy = 0; e_px = 0; e_py = 0; e_ad = 0; e_ig = 0; e_ov = 0;
  endtask

  task automatic model_sample(input int h, input int v, input int s);
    if (v != m_lv) begin
      if (v == Y_OFF) begin
        m_vl = 1; m_scr = (s >= CHARH) ? 0 : s;
      end else if (v < Y_OFF || v >= Y_OFF + CHARH*PIXH) m_vl = 0;
      else if (!(m_vl && v == m_lv + 1)) m_vl = 0;
      m_lv = v;
    end
    if (h == X_OFF) m_hl = 1;
    else if (h < X_OFF || h >= X_OFF + CHARW*PIXW) m_hl = 0;
    else if (!(m_hl && (h == m_lh + 1 || h == m_lh))) m_hl = 0;
    m_lh = h;
    e_ig = m_hl && m_vl;
    e_ov = 1;
    if (e_ig) begin
      e_cx = (h - X_OFF) / PIXW;
      e_px = (h - X_OFF) % PIXW;
      e_py = (v - Y_OFF) % PIXH;
      e_cy = ((v - Y_OFF) / PIXH + m_scr) % CHARH;
      e_ad = e_cy * CHARW + e_cx;
    end else begin
      e_cx = 0; e_px = 0; e_py = 0; e_cy = 0; e_ad = 0;
    end
  endtask

  // Compare process: model follows the same sampled inputs, outputs checked 1 ns later
  always begin
    @(posedge clk);
    if (!rst) model_reset();
    else if (pix_en) model_sample(int'(h_addr), int'(v_addr), int'(scroll_row));
    else e_ov = 0;
    #1;
    chk("out_valid", out_valid, int'(e_ov));
    chk("in_grid",   in_grid,   int'(e_ig));
    chk("char_x",    char_x,    e_cx);
    chk("char_y",    char_y,    e_cy);
    chk("pixel_x",   pixel_x,   e_px);
    chk("pixel_y",   pixel_y,   e_py);
    chk("char_addr", char_addr, e_ad);
  end

  task automatic step(input bit pe, input int h, input int v);
    @(negedge clk);
    pix_en = pe;
    h_addr = h[9:0];
    v_addr = v[9:0];
    @(posedge clk);
    #2;
  endtask

  initial begin : watchdog
    #5000000;
    n_err++;
    $display("FAIL watchdog: simulation exceeded time budget");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int h, v;
    // Reset state
    step(1, 5, 0);
    step(0, 0, 0);
    chk("rst_in_grid", in_grid, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_char_addr", char_addr, 0);
    @(negedge clk);
    rst = 1'b1;

    // Full lines v=0..16, no scroll, a short stall after each line
    for (int vv = 0; vv <= 16; vv++) begin
      for (int hh = 0; hh < 640; hh++) begin
        step(1, hh, vv);
        if (vv == 0 && hh == 4) chk("pin_h4_ingrid", in_grid, 0);
        if (vv == 0 && hh == 5) begin
          chk("pin_h5_ingrid", in_grid, 1);
          chk("pin_h5_cx", char_x, 0);
          chk("pin_h5_px", pixel_x, 0);
        end
        if (vv == 0 && hh == 14) begin
          chk("pin_h14_cx", char_x, 1);
          chk("pin_h14_px", pixel_x, 0);
          chk("pin_h14_addr", char_addr, 1);
        end
        if (vv == 0 && hh == 634) begin
          chk("pin_h634_cx", char_x, 69);
          chk("pin_h634_px", pixel_x, 8);
        end
        if (vv == 0 && hh == 635) begin
          chk("pin_h635_ingrid", in_grid, 0);
          chk("pin_h635_cx", char_x, 0);
        end
        if (vv == 15 && hh == 20) begin
          chk("pin_v15_py", pixel_y, 15);
          chk("pin_v15_cy", char_y, 0);
        end
        if (vv == 16 && hh == 20) begin
          chk("pin_v16_cy", char_y, 1);
          chk("pin_v16_py", pixel_y, 0);
          chk("pin_v16_addr", char_addr, 71);
        end
      end
      step(0, 639, vv);
      chk("pin_stall_ov", out_valid, 0);
      step(0, 100, vv);
    end

    // Scroll 29 latched at frame top; a mid-frame change must not take effect
    scroll_row = 5'd29;
    for (int vv = 0; vv <= 110; vv++) begin
      if (vv == 100) scroll_row = 5'd3;
      for (int hh = 3; hh <= 8; hh++) begin
        step(1, hh, vv);
        if (vv == 0 && hh == 5) begin
          chk("pin_scr_cy29", char_y, 29);
          chk("pin_scr_addr2030", char_addr, 2030);
        end
        if (vv == 16 && hh == 6) chk("pin_scr_wrap_cy", char_y, 0);
        if (vv == 105 && hh == 5) chk("pin_scr_nochange_cy", char_y, 5);
      end
    end

    // Next frame picks up scroll 3; run to the bottom edge of the grid
    for (int vv = 0; vv <= 490; vv++) begin
      for (int hh = 4; hh <= 6; hh++) begin
        step(1, hh, vv);
        if (vv == 0 && hh == 5) begin
          chk("pin_scr3_cy", char_y, 3);
          chk("pin_scr3_addr", char_addr, 210);
        end
        if (vv == 479 && hh == 5) begin
          chk("pin_v479_cy", char_y, 2);
          chk("pin_v479_py", pixel_y, 15);
          chk("pin_v479_addr", char_addr, 140);
        end
        if (vv == 480 && hh == 5) chk("pin_v480_ingrid", in_grid, 0);
      end
    end

    // Simultaneous origin on both axes; out-of-range scroll clamps to 0
    scroll_row = 5'd31;
    step(1, 5, 0);
    chk("pin_both_ingrid", in_grid, 1);
    chk("pin_clamp_cy", char_y, 0);
    step(1, 6, 0);
    scroll_row = 5'd0;

    // Horizontal jump drops lock for the rest of the line; vertical jump until frame top
    for (int vv = 1; vv <= 50; vv++)
      for (int hh = 4; hh <= 6; hh++) step(1, hh, vv);
    for (int hh = 3; hh <= 20; hh++) step(1, hh, 50);
    step(1, 40, 50);
    chk("pin_hjump_ingrid", in_grid, 0);
    for (int hh = 41; hh <= 45; hh++) step(1, hh, 50);
    chk("pin_hjump_stays", in_grid, 0);
    for (int hh = 3; hh <= 6; hh++) begin
      step(1, hh, 51);
      if (hh == 5) chk("pin_hrelock", in_grid, 1);
    end
    for (int hh = 3; hh <= 6; hh++) begin
      step(1, hh, 60);
      if (hh == 5) chk("pin_vjump_ingrid", in_grid, 0);
    end
    for (int hh = 3; hh <= 6; hh++) step(1, hh, 61);
    for (int hh = 3; hh <= 6; hh++) begin
      step(1, hh, 0);
      if (hh == 5) chk("pin_vrelock", in_grid, 1);
    end

    // Asynchronous reset mid-line with pix_en held high
    for (int hh = 0; hh <= 300; hh++) step(1, hh, 1);
    chk("pin_prerst_ingrid", in_grid, 1);
    #1 rst = 1'b0;
    #1;
    chk("pin_async_ingrid", in_grid, 0);
    chk("pin_async_cx", char_x, 0);
    chk("pin_async_ov", out_valid, 0);
    chk("pin_async_addr", char_addr, 0);
    step(1, 301, 1);
    step(1, 302, 1);
    rst = 1'b1;
    for (int hh = 303; hh <= 320; hh++) begin
      step(1, hh, 1);
      if (hh == 303) chk("pin_postrst_ov", out_valid, 1);
      if (hh == 310) chk("pin_postrst_ingrid", in_grid, 0);
    end
    for (int hh = 0; hh <= 10; hh++) begin
      step(1, hh, 2);
      if (hh == 5) chk("pin_postrst_v2", in_grid, 0);
    end
    for (int hh = 0; hh <= 10; hh++) begin
      step(1, hh, 0);
      if (hh == 5) chk("pin_postrst_relock", in_grid, 1);
    end

    // Randomized scan: stalls, repeats, h/v jumps, short lines, scroll changes
    h = 0;
    v = 0;
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (r < 3) h = int'($urandom_range(0, 700));
      else if (r < 8) h = h;
      else h = h + 1;
      if (h >= 650 || (h >= 30 && $urandom_range(0, 19) == 0)) begin
        h = 0;
        v = v + 1;
        if (v >= 40 && $urandom_range(0, 3) == 0) v = 0;
        else if ($urandom_range(0, 29) == 0) v = int'($urandom_range(0, 60));
      end
      if ($urandom_range(0, 49) == 0) scroll_row = 5'($urandom_range(0, 31));
      step(($urandom_range(0, 9) != 0), h, v);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
